// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uc_pkg
// Brief    : Shared types and encodings for the multicycle MIPS control unit:
//            state enumeration, opcode/funct constants, datapath mux codes.
// Revision : 1.0 - initial release
// ============================================================================
package uc_pkg;

  localparam int STATE_ENC_W = 6;

  typedef enum logic [STATE_ENC_W-1:0] {
    S_FETCH      = 6'd0,
    S_FETCH_WAIT = 6'd1,
    S_IR_LOAD    = 6'd2,
    S_DECODE     = 6'd3,
    S_RTYPE_EX   = 6'd4,
    S_RTYPE_WB   = 6'd5,
    S_ADDI_EX    = 6'd6,
    S_ADDI_WB    = 6'd7,
    S_BEQ        = 6'd8,
    S_BNE        = 6'd9,
    S_MEM_ADDR   = 6'd10,
    S_LW_RD      = 6'd11,
    S_LW_WAIT    = 6'd12,
    S_LW_WB      = 6'd13,
    S_SW_WR      = 6'd14,
    S_SW_WAIT    = 6'd15,
    S_LUI        = 6'd16,
    S_J          = 6'd17,
    S_JR         = 6'd18,
    S_BREAK      = 6'd19,
    S_ILLEGAL    = 6'd20
  } state_t;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;

  // Funct field IR[5:0] for the special R-type encodings
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  // True for the states that stall on memory latency
  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH_WAIT) || (s == S_LW_WAIT) || (s == S_SW_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uc_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : uc_wait_counter
// Brief    : Counts cycles spent in a memory wait state. Instruction fetch
//            waits MEM_WAIT cycles; data accesses (long_i) wait one more so
//            the read data / write completes before the next state.
// Revision : 1.0 - initial release
// ============================================================================
module uc_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic long_i,
  output logic done_o
);

  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Restart at zero whenever outside a wait state, step once per wait cycle
  always_ff @(posedge Clk) begin
    if (Reset || clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  generate
    if (MEM_WAIT == 0) begin : g_nowait
      // Fetch never stalls; a data wait lasts exactly one cycle
      assign done_o = long_i ? (cnt_q == '0) : 1'b1;
    end else begin : g_wait
      localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(MEM_WAIT - 1);
      localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(MEM_WAIT);
      assign done_o = (cnt_q == (long_i ? LAST_LONG : LAST_SHORT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uc_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : uc_multicycle
// Brief    : Multicycle MIPS control unit. Moore FSM producing datapath mux
//            selects and write enables, with memory wait states, halt at
//            instruction boundary and sticky illegal-opcode trap.
// Revision : 1.0 - initial release
// ============================================================================
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int STATE_W  = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               HaltReq,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               AWrite,
  output logic               BWrite,
  output logic               ALUOutWrite,
  output logic               MDRWrite,
  output logic               BranchNe,
  output logic               Halted,
  output logic               Exception,
  output logic [STATE_W-1:0] State_out
);

  state_t               state_q, state_d;
  state_t               end_state;
  logic                 halt_q;
  logic [STATE_W-1:0]   state_out_q;
  logic                 wait_done;

  uc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (!is_wait(state_q)),
    .en_i    (is_wait(state_q)),
    .long_i  (state_q != S_FETCH_WAIT),
    .done_o  (wait_done)
  );

  // Next-state selection; a request seen in the final cycle still halts here
  always_comb begin
    end_state = (halt_q || HaltReq) ? S_BREAK : S_FETCH;
    state_d   = state_q;
    case (state_q)
      S_FETCH:      state_d = (MEM_WAIT > 0) ? S_FETCH_WAIT : S_IR_LOAD;
      S_FETCH_WAIT: if (wait_done) state_d = S_IR_LOAD;
      S_IR_LOAD:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE: begin
            if (Funct == FN_JR)         state_d = S_JR;
            else if (Funct == FN_BREAK) state_d = S_BREAK;
            else                        state_d = S_RTYPE_EX;
          end
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_BEQ:        state_d = S_BEQ;
          OP_BNE:        state_d = S_BNE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_LUI:        state_d = S_LUI;
          OP_J:          state_d = S_J;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_RTYPE_EX:   state_d = S_RTYPE_WB;
      S_ADDI_EX:    state_d = S_ADDI_WB;
      S_MEM_ADDR:   state_d = (Op == OP_SW) ? S_SW_WR : S_LW_RD;
      S_LW_RD:      state_d = S_LW_WAIT;
      S_LW_WAIT:    if (wait_done) state_d = S_LW_WB;
      S_SW_WR:      state_d = S_SW_WAIT;
      S_SW_WAIT:    if (wait_done) state_d = end_state;
      S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_BNE, S_LW_WB, S_LUI, S_J, S_JR:
                    state_d = end_state;
      S_BREAK:      state_d = S_BREAK;
      S_ILLEGAL:    state_d = S_ILLEGAL;
      default:      state_d = S_FETCH;
    endcase
  end

  // State, sticky halt flag and the one-cycle-delayed state copy
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_FETCH;
      halt_q      <= 1'b0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_q | HaltReq;
      state_out_q <= STATE_W'(state_q);
    end
  end

  assign State_out = state_out_q;

  // Moore output decode; anything not named for a state stays low
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCS_ALU;
    ALUOp       = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    ALUOutWrite = 1'b0;
    MDRWrite    = 1'b0;
    BranchNe    = 1'b0;
    Halted      = 1'b0;
    Exception   = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_WAIT: ALUSrcB = SRCB_FOUR;
      S_IR_LOAD: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUSrcB     = SRCB_IMM_S2;
        ALUOutWrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_FUNCT;
        ALUOutWrite = 1'b1;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOutWrite = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_BEQ, S_BNE: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        BranchNe    = (state_q == S_BNE);
      end
      S_LW_RD, S_SW_WAIT: IorD = 1'b1;
      S_LW_WAIT: begin
        IorD     = 1'b1;
        MDRWrite = wait_done;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ALU_LUI;
        RegWrite = 1'b1;
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCS_REGA;
      end
      S_BREAK:   Halted    = 1'b1;
      S_ILLEGAL: Exception = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uc_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_multicycle
// Brief    : Scoreboard bench for uc_multicycle at MEM_WAIT = 0, 2 and 3.
//            Each driver expands random instructions into the expected
//            per-cycle state walk and pushes expected outputs; one monitor
//            pops and compares every cycle for all three instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uc_multicycle;
  import uc_pkg::*;

  localparam int NW     = 3;
  localparam int NINSTR = 60;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic       pcw, pcwc, iord, memw, mtr, irw;
    logic [1:0] pcs;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       regw, regdst, aw, bw, aluoutw, mdrw, bne, halted, exc;
  } ctl_t;

  typedef struct packed {
    ctl_t       ctl;
    logic [5:0] so;
    logic [5:0] st;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   checks   = 0;
  int   failures = 0;
  ctl_t act   [NW];
  logic [5:0] so_act [NW];
  bit   done_f [NW];
  exp_t sbq   [NW][$];

  // Expected outputs of one state, taken from the per-state output table
  function automatic ctl_t exp_ctl(input state_t s, input bit mdr);
    ctl_t c = '0;
    case (s)
      S_FETCH, S_FETCH_WAIT: c.srcb = 2'b01;
      S_IR_LOAD:  begin c.irw = 1; c.pcw = 1; c.srcb = 2'b01; end
      S_DECODE:   begin c.aw = 1; c.bw = 1; c.srcb = 2'b11; c.aluoutw = 1; end
      S_RTYPE_EX: begin c.srca = 1; c.aluop = 3'b010; c.aluoutw = 1; end
      S_RTYPE_WB: begin c.regw = 1; c.regdst = 1; end
      S_ADDI_EX:  begin c.srca = 1; c.srcb = 2'b10; c.aluoutw = 1; end
      S_ADDI_WB:  c.regw = 1;
      S_BEQ:      begin c.srca = 1; c.aluop = 3'b001; c.pcwc = 1; c.pcs = 2'b01; end
      S_BNE:      begin c.srca = 1; c.aluop = 3'b001; c.pcwc = 1; c.pcs = 2'b01; c.bne = 1; end
      S_MEM_ADDR: begin c.srca = 1; c.srcb = 2'b10; c.aluoutw = 1; end
      S_LW_RD:    c.iord = 1;
      S_LW_WAIT:  begin c.iord = 1; c.mdrw = mdr; end
      S_LW_WB:    begin c.regw = 1; c.mtr = 1; end
      S_SW_WR:    begin c.iord = 1; c.memw = 1; end
      S_SW_WAIT:  c.iord = 1;
      S_LUI:      begin c.srcb = 2'b10; c.aluop = 3'b100; c.regw = 1; end
      S_J:        begin c.pcw = 1; c.pcs = 2'b10; end
      S_JR:       begin c.pcw = 1; c.pcs = 2'b11; end
      S_BREAK:    c.halted = 1;
      S_ILLEGAL:  c.exc = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02};
  endfunction

  for (genvar g = 0; g < NW; g++) begin : g_inst
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

    logic       Reset, HaltReq;
    logic [5:0] Op, Funct;
    logic       pcw, pcwc, iord, memw, mtr, irw, srca;
    logic       regw, regdst, aw, bw, aluoutw, mdrw, bne, halted, exc;
    logic [1:0] pcs, srcb;
    logic [2:0] aluop;
    logic [5:0] so;

    uc_multicycle #(.MEM_WAIT(W), .STATE_W(6)) dut (
      .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .HaltReq(HaltReq),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemWrite(memw),
      .MemtoReg(mtr), .IRWrite(irw), .PCSource(pcs), .ALUOp(aluop),
      .ALUSrcA(srca), .ALUSrcB(srcb), .RegWrite(regw), .RegDst(regdst),
      .AWrite(aw), .BWrite(bw), .ALUOutWrite(aluoutw), .MDRWrite(mdrw),
      .BranchNe(bne), .Halted(halted), .Exception(exc), .State_out(so)
    );

    assign act[g] = {pcw, pcwc, iord, memw, mtr, irw, pcs, aluop, srca, srcb,
                     regw, regdst, aw, bw, aluoutw, mdrw, bne, halted, exc};
    assign so_act[g] = so;

    state_t sl[$];
    bit     ml[$];

    task automatic add(input state_t s, input bit m);
      sl.push_back(s);
      ml.push_back(m);
    endtask

    // One cycle of stimulus: present inputs, push expectation, advance
    task automatic step(input state_t s, input bit m, input bit hreq,
                        input bit rst, inout state_t prev);
      exp_t e;
      HaltReq = hreq;
      Reset   = rst;
      e.ctl   = exp_ctl(s, m);
      e.so    = prev;
      e.st    = s;
      sbq[g].push_back(e);
      prev = rst ? S_FETCH : s;
      @(posedge Clk);
      #1;
      Reset   = 1'b0;
      HaltReq = 1'b0;
    endtask

    initial begin : drv
      state_t     prev;
      logic [5:0] op, fn;
      int         kind, halt_at, reset_at;
      bit         halt_pend, absorb, was_reset;
      state_t     absorb_s;

      Reset = 1'b1; HaltReq = 1'b0; Op = '0; Funct = '0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      prev  = S_FETCH;

      for (int n = 0; n < NINSTR; n++) begin
        halt_at = -1; reset_at = -1; absorb = 0; absorb_s = S_BREAK;
        fn = 6'($urandom_range(0, 63));
        kind = (n < 13) ? n + 100 : $urandom_range(0, 11);
        case (kind)
          100:    begin op = 6'h00; fn = 6'h20; end
          101:    op = 6'h23;
          102:    op = 6'h2B;
          103:    op = 6'h05;
          104:    op = 6'h04;
          105:    op = 6'h08;
          106:    op = 6'h0F;
          107:    op = 6'h02;
          108:    begin op = 6'h00; fn = 6'h08; end
          109:    op = 6'h23;
          110:    begin op = 6'h00; fn = 6'h0D; end
          111:    op = 6'h3F;
          112:    op = 6'h2B;
          0, 1: begin
            op = 6'h00;
            while (fn == 6'h08 || fn == 6'h0D) fn = 6'($urandom_range(0, 63));
          end
          2:  op = 6'h08;
          3:  op = 6'h04;
          4:  op = 6'h05;
          5, 6: op = 6'h23;
          7:  op = 6'h2B;
          8:  op = 6'h0F;
          9:  op = 6'h02;
          10: begin op = 6'h00; fn = 6'h08; end
          default: begin
            if ($urandom_range(0, 1) == 0) begin
              op = 6'h00; fn = 6'h0D;
            end else begin
              op = 6'($urandom_range(0, 63));
              while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end
          end
        endcase
        Op = op;
        Funct = fn;

        // Expected state walk of this instruction
        sl.delete(); ml.delete();
        add(S_FETCH, 0);
        for (int i = 0; i < W; i++) add(S_FETCH_WAIT, 0);
        add(S_IR_LOAD, 0);
        add(S_DECODE, 0);
        if (op == 6'h00 && fn == 6'h08) add(S_JR, 0);
        else if (op == 6'h00 && fn == 6'h0D) absorb = 1;
        else if (op == 6'h00) begin add(S_RTYPE_EX, 0); add(S_RTYPE_WB, 0); end
        else if (op == 6'h08) begin add(S_ADDI_EX, 0); add(S_ADDI_WB, 0); end
        else if (op == 6'h04) add(S_BEQ, 0);
        else if (op == 6'h05) add(S_BNE, 0);
        else if (op == 6'h0F) add(S_LUI, 0);
        else if (op == 6'h02) add(S_J, 0);
        else if (op == 6'h23) begin
          add(S_MEM_ADDR, 0); add(S_LW_RD, 0);
          for (int i = 0; i <= W; i++) add(S_LW_WAIT, i == W);
          add(S_LW_WB, 0);
        end else if (op == 6'h2B) begin
          add(S_MEM_ADDR, 0); add(S_SW_WR, 0);
          for (int i = 0; i <= W; i++) add(S_SW_WAIT, 0);
        end else begin
          absorb = 1; absorb_s = S_ILLEGAL;
        end
        if (absorb) begin
          for (int i = 0; i < 3; i++) add(absorb_s, 0);
          reset_at = sl.size() - 1;
        end

        // Halt / reset injection points
        if (kind == 109) begin
          foreach (sl[i]) if (halt_at < 0 && sl[i] == S_LW_WAIT) halt_at = i;
        end else if (kind == 112) begin
          foreach (sl[i]) if (sl[i] == S_SW_WR) reset_at = i;
        end else if (!absorb && kind < 100) begin
          if ($urandom_range(0, 7) == 0) halt_at = $urandom_range(0, sl.size() - 1);
          else if ($urandom_range(0, 9) == 0) reset_at = $urandom_range(0, sl.size() - 1);
        end

        halt_pend = 0; was_reset = 0;
        for (int i = 0; i < sl.size(); i++) begin
          if (i == halt_at) halt_pend = 1;
          step(sl[i], ml[i], i == halt_at, i == reset_at, prev);
          if (i == reset_at) begin was_reset = 1; break; end
        end

        // Halt taken at the boundary: BREAK holds until reset
        if (!was_reset && halt_pend) begin
          Op = 6'($urandom_range(0, 63));
          for (int i = 0; i < 4; i++) step(S_BREAK, 0, 0, i == 3, prev);
        end
      end
      done_f[g] = 1;
    end
  end

  // Monitor: every cycle each instance with a pending expectation is checked
  initial begin : mon
    exp_t e;
    int   cyc;
    bit   all_done;
    cyc = 0;
    all_done = 0;
    while (!all_done && cyc < BUDGET) begin
      @(negedge Clk);
      cyc++;
      for (int k = 0; k < NW; k++) begin
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          checks++;
          if (act[k] !== e.ctl) begin
            failures++;
            $display("FAIL ctl inst=%0d cyc=%0d state=%0d got=%h want=%h",
                     k, cyc, e.st, act[k], e.ctl);
          end
          checks++;
          if (so_act[k] !== e.so) begin
            failures++;
            $display("FAIL state_out inst=%0d cyc=%0d state=%0d got=%0d want=%0d",
                     k, cyc, e.st, so_act[k], e.so);
          end
        end
      end
      all_done = 1;
      for (int k = 0; k < NW; k++)
        if (!done_f[k] || sbq[k].size() != 0) all_done = 0;
    end
    if (!all_done) begin
      failures++;
      $display("FAIL timeout cycles=%0d got=incomplete want=complete", cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
